// File: rtl/pmt_pkg.sv
// rtl/pmt_pkg.sv - shared types and constants for the PMT count serializer
package pmt_pkg;

    localparam int COUNT_W = 16;
    localparam logic [COUNT_W-1:0] TERM = 16'hFFFF;

    localparam logic [2:0] IDX_HI      = 3'd0;
    localparam logic [2:0] IDX_LO      = 3'd1;
    localparam logic [2:0] IDX_TERM_HI = 3'd2;
    localparam logic [2:0] IDX_TERM_LO = 3'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_ISSUE,
        ST_WAIT_DONE,
        ST_NEXT
    } state_t;

    typedef struct packed {
        logic               last;
        logic [COUNT_W-1:0] count;
    } bin_entry_t;

    // TERM is reserved as the end-of-run marker, so a saturated count is pulled just below it.
    function automatic logic [COUNT_W-1:0] clamp_count(input logic [COUNT_W-1:0] c);
        return (c == TERM) ? (TERM - 1'b1) : c;
    endfunction

endpackage

// File: rtl/pmt_sync_fifo.sv
// rtl/pmt_sync_fifo.sv - synchronous FIFO with registered level and full/empty flags
module pmt_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int W     = 17
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic [W-1:0]  push_data,
    input  logic          pop,
    output logic [W-1:0]  head,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level
);

    localparam logic [AW:0] LVL_FULL = (AW + 1)'(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A full FIFO still accepts a write when a read frees a slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (do_pop && !do_push) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign head  = mem[rd_ptr];
    assign full  = (level == LVL_FULL);
    assign empty = (level == '0);

endmodule

// File: rtl/pmt_count_serializer.sv
// rtl/pmt_count_serializer.sv - buffers timebin counts and streams them as byte pairs to the UART
module pmt_count_serializer
    import pmt_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int AW      = 4,
    parameter int TIMEOUT = 20000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bin_valid,
    input  logic [COUNT_W-1:0] bin_count,
    input  logic               bin_last,
    input  logic               uart_busy,
    input  logic               uart_tx_done,
    output logic               uart_transmit,
    output logic [7:0]         uart_tx_byte,
    output logic [AW:0]        fifo_level,
    output logic               overflow,
    output logic               tx_timeout,
    output logic               active
);

    localparam int TW = $clog2(TIMEOUT);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t             state;
    state_t             state_nx;
    bin_entry_t         push_entry;
    bin_entry_t         head_entry;
    logic               full;
    logic               empty;
    logic               fifo_pop;
    logic [COUNT_W-1:0] word;
    logic               last_f;
    logic [2:0]         byte_idx;
    logic [2:0]         idx_nx;
    logic [TW-1:0]      tmo_cnt;
    logic               tmo_hit;

    assign push_entry = '{last: bin_last, count: clamp_count(bin_count)};
    assign fifo_pop   = (state == ST_POP);
    assign idx_nx     = byte_idx + 3'd1;
    assign tmo_hit    = (tmo_cnt == TMO_LAST);

    pmt_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     ($bits(bin_entry_t))
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bin_valid),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (head_entry),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            ST_IDLE:      if (!empty) state_nx = ST_POP;
            ST_POP:       state_nx = ST_ISSUE;
            ST_ISSUE:     if (!uart_busy) state_nx = ST_WAIT_DONE;
            ST_WAIT_DONE: if (uart_tx_done || tmo_hit) state_nx = ST_NEXT;
            ST_NEXT: begin
                // The terminator pair is only sent after a word flagged as the last of its run.
                if (idx_nx == IDX_LO || idx_nx == IDX_TERM_LO || (idx_nx == IDX_TERM_HI && last_f))
                    state_nx = ST_ISSUE;
                else if (!empty)
                    state_nx = ST_POP;
                else
                    state_nx = ST_IDLE;
            end
            default:      state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        uart_transmit = (state == ST_ISSUE) && !uart_busy;
        active        = (state != ST_IDLE) || !empty;
        uart_tx_byte  = TERM[7:0];
        case (byte_idx)
            IDX_HI:      uart_tx_byte = word[15:8];
            IDX_LO:      uart_tx_byte = word[7:0];
            IDX_TERM_HI: uart_tx_byte = TERM[15:8];
            default:     uart_tx_byte = TERM[7:0];
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            word       <= '0;
            last_f     <= 1'b0;
            byte_idx   <= IDX_HI;
            tmo_cnt    <= '0;
            overflow   <= 1'b0;
            tx_timeout <= 1'b0;
        end else begin
            if (bin_valid && full && !fifo_pop) overflow <= 1'b1;
            case (state)
                ST_POP: begin
                    word     <= head_entry.count;
                    last_f   <= head_entry.last;
                    byte_idx <= IDX_HI;
                end
                ST_ISSUE:     if (!uart_busy) tmo_cnt <= '0;
                ST_WAIT_DONE: begin
                    if (!uart_tx_done) begin
                        if (tmo_hit) tx_timeout <= 1'b1;
                        else         tmo_cnt    <= tmo_cnt + 1'b1;
                    end
                end
                ST_NEXT:      byte_idx <= idx_nx;
                default:      ;
            endcase
        end
    end

endmodule

// File: tb/tb_pmt_count_serializer.sv
// tb/tb_pmt_count_serializer.sv - scoreboard bench for pmt_count_serializer
module tb_pmt_count_serializer;

    localparam int TIMEOUT = 20000;
    localparam int FRAME   = 100;

    logic        clk = 1'b0;
    logic        rst;
    logic        bin_valid;
    logic [15:0] bin_count;
    logic        bin_last;
    logic        uart_busy;
    logic        uart_tx_done;
    logic        uart_transmit;
    logic [7:0]  uart_tx_byte;
    logic [4:0]  fifo_level;
    logic        overflow;
    logic        tx_timeout;
    logic        active;

    logic        stall;
    logic        m_busy;
    logic        prev_tx = 1'b0;
    int          n_pass = 0;
    int          n_total = 0;
    int          pulse_cnt = 0;
    int          done_cnt = 0;
    int          frame_cnt = 0;
    int          drop_at = -1;
    int          cyc = 0;
    logic [7:0]  exp_q[$];

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    assign uart_busy = stall | m_busy;

    pmt_count_serializer #(.DEPTH(16), .AW(4), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst           (rst),
        .bin_valid     (bin_valid),
        .bin_count     (bin_count),
        .bin_last      (bin_last),
        .uart_busy     (uart_busy),
        .uart_tx_done  (uart_tx_done),
        .uart_transmit (uart_transmit),
        .uart_tx_byte  (uart_tx_byte),
        .fifo_level    (fifo_level),
        .overflow      (overflow),
        .tx_timeout    (tx_timeout),
        .active        (active)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // UART model: busy for FRAME cycles per byte, then a done pulse unless that frame is dropped.
    initial begin
        m_busy = 1'b0;
        uart_tx_done = 1'b0;
        forever begin
            @(negedge clk);
            if (uart_transmit === 1'b1) begin
                @(posedge clk); #1 m_busy = 1'b1;
                repeat (FRAME) @(posedge clk);
                #1 m_busy = 1'b0;
                if (frame_cnt != drop_at) begin
                    uart_tx_done = 1'b1;
                    done_cnt++;
                    @(posedge clk); #1 uart_tx_done = 1'b0;
                end
                frame_cnt++;
            end
        end
    end

    // Monitor: every transmit pulse must be one cycle wide and carry the next expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (uart_transmit === 1'b1) begin
                pulse_cnt++;
                check("tx_pulse_width", 32'(prev_tx), 0);
                if (exp_q.size() == 0) begin
                    n_total++;
                    $display("FAIL tx_unexpected: got byte 0x%0h expected none", uart_tx_byte);
                end else begin
                    check("tx_byte", 32'(uart_tx_byte), 32'(exp_q.pop_front()));
                end
            end
            prev_tx = uart_transmit;
        end
    end

    task automatic expect_word(input logic [15:0] w, input logic last);
        exp_q.push_back(w[15:8]);
        exp_q.push_back(w[7:0]);
        if (last) begin
            exp_q.push_back(8'hFF);
            exp_q.push_back(8'hFF);
        end
    endtask

    task automatic drive_bin(input logic [15:0] c, input logic last);
        @(posedge clk); #1;
        bin_valid = 1'b1;
        bin_count = c;
        bin_last  = last;
    endtask

    task automatic idle_bus();
        @(posedge clk); #1;
        bin_valid = 1'b0;
        bin_last  = 1'b0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1; bin_valid = 1'b0; stall = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rst_transmit", 32'(uart_transmit), 0);
        check("rst_level", 32'(fifo_level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_timeout", 32'(tx_timeout), 0);
        check("rst_active", 32'(active), 0);
        check("rst_byte", 32'(uart_tx_byte), 0);
    endtask

    task automatic wait_pulses(input int target, input int budget, input string name);
        int n = 0;
        while (pulse_cnt < target && n < budget) begin @(negedge clk); n++; end
        check(name, pulse_cnt, target);
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        int n = 0;
        while (done_cnt < target && n < budget) begin @(negedge clk); n++; end
        check(name, done_cnt, target);
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while ((active || uart_busy) && n < budget) begin @(negedge clk); n++; end
        check(name, 32'(active), 0);
    endtask

    initial begin
        int base;
        int t1;
        rst = 1'b1; bin_valid = 1'b0; bin_count = '0; bin_last = 1'b0; stall = 1'b0;
        repeat (2) @(posedge clk);
        do_reset();

        // 1: single bin, latency of three cycles, two pulses
        base = pulse_cnt;
        expect_word(16'h1234, 1'b0);
        drive_bin(16'h1234, 1'b0);
        idle_bus();
        @(negedge clk); check("lat_c1_tx", 32'(uart_transmit), 0);
        check("lat_c1_active", 32'(active), 1);
        @(negedge clk); check("lat_c2_tx", 32'(uart_transmit), 0);
        @(negedge clk); check("lat_c3_tx", 32'(uart_transmit), 1);
        wait_idle(1000, "t1_idle");
        check("t1_pulses", pulse_cnt - base, 2);

        // 2: clamp and terminator, active falls two cycles after the final done
        base = done_cnt;
        expect_word(16'h0001, 1'b0);
        expect_word(16'hFFFE, 1'b1);
        drive_bin(16'h0001, 1'b0);
        drive_bin(16'hFFFF, 1'b1);
        idle_bus();
        wait_done(base + 6, 2000, "t2_done");
        check("t2_active_done", 32'(active), 1);
        @(negedge clk); check("t2_active_next", 32'(active), 1);
        @(negedge clk); check("t2_active_idle", 32'(active), 0);

        // 3: overflow while the UART is stalled
        base = pulse_cnt;
        @(posedge clk); #1 stall = 1'b1;
        expect_word(16'h0AAA, 1'b0);
        drive_bin(16'h0AAA, 1'b0);
        idle_bus();
        repeat (5) @(posedge clk);
        for (int i = 0; i < 20; i++) begin
            drive_bin(16'(16'h0100 + i), 1'b0);
            if (i < 16) expect_word(16'(16'h0100 + i), 1'b0);
        end
        idle_bus();
        @(negedge clk);
        check("t3_overflow", 32'(overflow), 1);
        check("t3_level", 32'(fifo_level), 16);
        check("t3_tx_stalled", 32'(uart_transmit), 0);
        @(posedge clk); #1 stall = 1'b0;
        wait_pulses(base + 34, 10000, "t3_pulses");
        wait_idle(1000, "t3_idle");

        // 4: full FIFO accepts a bin in the POP cycle
        do_reset();
        @(posedge clk); #1 stall = 1'b1;
        expect_word(16'h0BBB, 1'b0);
        drive_bin(16'h0BBB, 1'b0);
        idle_bus();
        repeat (5) @(posedge clk);
        for (int i = 0; i < 16; i++) begin
            drive_bin(16'(16'h0200 + i), 1'b0);
            expect_word(16'(16'h0200 + i), 1'b0);
        end
        idle_bus();
        @(negedge clk);
        check("t4_full_level", 32'(fifo_level), 16);
        base = done_cnt;
        @(posedge clk); #1 stall = 1'b0;
        wait_done(base + 2, 1000, "t4_done");
        check("t4_level_before_pop", 32'(fifo_level), 16);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bin_valid = 1'b1; bin_count = 16'h0CCC; bin_last = 1'b0;
        expect_word(16'h0CCC, 1'b0);
        idle_bus();
        @(negedge clk);
        check("t4_level_after", 32'(fifo_level), 16);
        check("t4_overflow", 32'(overflow), 0);
        wait_idle(10000, "t4_idle");

        // 5: missing tx_done times out and the next byte still goes out
        base = pulse_cnt;
        drop_at = frame_cnt;
        expect_word(16'h5AA5, 1'b0);
        drive_bin(16'h5AA5, 1'b0);
        idle_bus();
        wait_pulses(base + 1, 50, "t5_first");
        t1 = cyc;
        check("t5_timeout_before", 32'(tx_timeout), 0);
        wait_pulses(base + 2, TIMEOUT + 200, "t5_second");
        check("t5_spacing", cyc - t1, TIMEOUT + 2);
        check("t5_timeout_after", 32'(tx_timeout), 1);
        wait_idle(1000, "t5_idle");

        // 6: reset in WAIT_DONE with three words queued
        base = pulse_cnt;
        @(posedge clk); #1 stall = 1'b1;
        exp_q.push_back(8'h0D);
        for (int i = 0; i < 4; i++) drive_bin(16'(16'h0D00 + i), 1'b0);
        idle_bus();
        repeat (5) @(posedge clk);
        #1 stall = 1'b0;
        wait_pulses(base + 1, 50, "t6_first");
        repeat (10) @(negedge clk);
        check("t6_level_queued", 32'(fifo_level), 3);
        check("t6_timeout_sticky", 32'(tx_timeout), 1);
        do_reset();
        repeat (300) @(negedge clk);
        check("t6_no_more_tx", pulse_cnt - base, 1);
        check("final_queue_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #4_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

endmodule
